// File: rtl/sub32_slice_seq.sv
// Sequential add/subtract unit: one SLICE_W-bit adder slice reused over WIDTH/SLICE_W cycles.
// Optional signed-overflow output is built only when SUB32_OVF_EN is defined.
//
// state  | meaning
// IDLE   | in_ready high, waiting for an operand request
// BUSY   | one slice per cycle, carry passed between cycles in carry_q
// DONE   | out_valid high, result held until out_ready
module sub32_slice_seq #(
  parameter int WIDTH   = 32,
  parameter int SLICE_W = 16
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
`ifdef SUB32_OVF_EN
  output logic             ovf,
`endif
  output logic             c_out
);

  localparam int NS    = WIDTH / SLICE_W;
  localparam int IDX_W = (NS > 1) ? $clog2(NS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             op_sub_q, op_sub_d;
  logic             c_out_q, c_out_d;
  logic [IDX_W-1:0] idx_q, idx_d;
`ifdef SUB32_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [SLICE_W-1:0] a_s, b_s;
  logic [SLICE_W:0]   sum_s;
  logic               last_s;

  // The single shared slice adder; b_q already holds ~b for subtraction.
  always_comb begin
    a_s    = a_q[int'(idx_q) * SLICE_W +: SLICE_W];
    b_s    = b_q[int'(idx_q) * SLICE_W +: SLICE_W];
    sum_s  = {1'b0, a_s} + {1'b0, b_s} + {{SLICE_W{1'b0}}, carry_q};
    last_s = (idx_q == IDX_W'(NS - 1));
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    op_sub_d = op_sub_q;
    c_out_d  = c_out_q;
    idx_d    = idx_q;
`ifdef SUB32_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = op_sub ? ~b : b;
          carry_d  = op_sub;
          op_sub_d = op_sub;
          idx_d    = '0;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        result_d[int'(idx_q) * SLICE_W +: SLICE_W] = sum_s[SLICE_W-1:0];
        carry_d = sum_s[SLICE_W];
        idx_d   = idx_q + 1'b1;
        if (last_s) begin
          state_d = S_DONE;
          c_out_d = sum_s[SLICE_W] ^ op_sub_q;
`ifdef SUB32_OVF_EN
          // carry into the MSB is recovered from the MSB sum bit and operand bits
          ovf_d = (a_s[SLICE_W-1] ^ b_s[SLICE_W-1] ^ sum_s[SLICE_W-1]) ^ sum_s[SLICE_W];
`endif
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      op_sub_q <= 1'b0;
      c_out_q  <= 1'b0;
      idx_q    <= '0;
`ifdef SUB32_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      op_sub_q <= op_sub_d;
      c_out_q  <= c_out_d;
      idx_q    <= idx_d;
`ifdef SUB32_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign c_out     = c_out_q;
`ifdef SUB32_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_sub32_slice_seq.sv
// Bench for sub32_slice_seq: directed cases on a 32-bit instance, random add/sub with
// back-pressure on a 48-bit instance, both against an arithmetic reference model.
module tb_sub32_slice_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic areset;

  logic        iv32, ir32, op32, ov32, or32, c32;
  logic [31:0] a32, b32, r32;
  logic        iv48, ir48, op48, ov48, or48, c48;
  logic [47:0] a48, b48, r48;
`ifdef SUB32_OVF_EN
  logic        f32, f48;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  sub32_slice_seq #(.WIDTH(32), .SLICE_W(16)) u_dut32 (
    .clk(clk), .areset(areset), .in_valid(iv32), .in_ready(ir32), .op_sub(op32),
    .a(a32), .b(b32), .out_valid(ov32), .out_ready(or32), .result(r32),
`ifdef SUB32_OVF_EN
    .ovf(f32),
`endif
    .c_out(c32)
  );

  sub32_slice_seq #(.WIDTH(48), .SLICE_W(16)) u_dut48 (
    .clk(clk), .areset(areset), .in_valid(iv48), .in_ready(ir48), .op_sub(op48),
    .a(a48), .b(b48), .out_valid(ov48), .out_ready(or48), .result(r48),
`ifdef SUB32_OVF_EN
    .ovf(f48),
`endif
    .c_out(c48)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Plain modular arithmetic: borrow is a<b, overflow from operand/result signs.
  task automatic ref_model(input int w, input logic op, input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] r, output logic c, output logic v);
    logic [63:0] mask, full;
    logic sa, sb, sr;
    mask = (64'd1 << w) - 64'd1;
    if (!op) begin
      full = a + b;
      c    = full[w];
      r    = full & mask;
    end else begin
      r = (a - b) & mask;
      c = (a < b);
    end
    sa = a[w-1]; sb = b[w-1]; sr = r[w-1];
    v  = op ? (sa != sb && sr != sa) : (sa == sb && sr != sa);
  endtask

  // Entered and left at posedge+1.
  task automatic run32(input logic op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic c, output logic v, output int lat);
    int n;
    iv32 = 1'b1; op32 = op; a32 = a; b32 = b;
    n = 0;
    while (!ir32 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    iv32 = 1'b0; a32 = $urandom; b32 = $urandom; op32 = 1'($urandom);
    lat = 0;
    while (!ov32 && lat < 20) begin @(posedge clk); #1; lat++; end
    r = r32; c = c32;
`ifdef SUB32_OVF_EN
    v = f32;
`else
    v = 1'b0;
`endif
    or32 = 1'b1;
    @(posedge clk); #1;
    or32 = 1'b0;
    chk("ov32_clear", 64'(ov32), 64'd0);
    chk("ir32_back", 64'(ir32), 64'd1);
  endtask

  task automatic run48(input logic op, input logic [47:0] a, input logic [47:0] b, input int hold,
                       output logic [47:0] r, output logic c, output logic v, output int lat);
    int n;
    iv48 = 1'b1; op48 = op; a48 = a; b48 = b;
    n = 0;
    while (!ir48 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    iv48 = 1'b0; a48 = {$urandom, $urandom}; b48 = {$urandom, $urandom}; op48 = 1'($urandom);
    lat = 0;
    while (!ov48 && lat < 20) begin @(posedge clk); #1; lat++; end
    repeat (hold) @(posedge clk);
    #1;
    r = r48; c = c48;
`ifdef SUB32_OVF_EN
    v = f48;
`else
    v = 1'b0;
`endif
    or48 = 1'b1;
    @(posedge clk); #1;
    or48 = 1'b0;
  endtask

  task automatic dir32(input string tag, input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ec, input logic ev);
    logic [31:0] r;
    logic c, v;
    int lat;
    run32(op, a, b, r, c, v, lat);
    chk({tag, "_res"}, 64'(r), 64'(er));
    chk({tag, "_cout"}, 64'(c), 64'(ec));
    chk({tag, "_lat"}, 64'(lat), 64'd2);
`ifdef SUB32_OVF_EN
    chk({tag, "_ovf"}, 64'(v), 64'(ev));
`else
    if (ev) $display("note: %s expects overflow, port not built", tag);
`endif
  endtask

  initial begin
    logic [47:0] ra, rb, rr, mask48;
    logic [63:0] er;
    logic rc, rv, ec, ev, op;
    int lat, hold, gap;

    areset = 1'b1;
    iv32 = 0; op32 = 0; a32 = 0; b32 = 0; or32 = 0;
    iv48 = 0; op48 = 0; a48 = 0; b48 = 0; or48 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ir32", 64'(ir32), 64'd1);
    chk("rst_ov32", 64'(ov32), 64'd0);
    chk("rst_r32", 64'(r32), 64'd0);
    chk("rst_c32", 64'(c32), 64'd0);
    chk("rst_ir48", 64'(ir48), 64'd1);
    chk("rst_ov48", 64'(ov48), 64'd0);
`ifdef SUB32_OVF_EN
    chk("rst_f32", 64'(f32), 64'd0);
`endif
    #2 areset = 1'b0;
    @(posedge clk); #1;

    dir32("add_carry", 1'b0, 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, 1'b0);
    dir32("sub_borrow", 1'b1, 32'h00010000, 32'h00000001, 32'h0000FFFF, 1'b0, 1'b0);
    dir32("sub_wrap", 1'b1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0);
`ifdef SUB32_OVF_EN
    dir32("sub_ovf", 1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1);
    dir32("add_ovf", 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1);
`endif

    // add FFFFFFFF+1 with out_ready held low and a competing request pending
    iv32 = 1'b1; op32 = 1'b0; a32 = 32'hFFFFFFFF; b32 = 32'h00000001;
    @(posedge clk); #1;
    a32 = 32'h11111111; b32 = 32'h22222222; op32 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("hold_ov_rise", 64'(ov32), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_res", 64'(r32), 64'h0);
      chk("hold_cout", 64'(c32), 64'd1);
      chk("hold_ir", 64'(ir32), 64'd0);
      chk("hold_ov", 64'(ov32), 64'd1);
    end
    or32 = 1'b1;
    @(posedge clk); #1;
    or32 = 1'b0; iv32 = 1'b0;
    chk("hs_ir", 64'(ir32), 64'd1);
    chk("hs_ov", 64'(ov32), 64'd0);
    chk("hs_res_kept", 64'(r32), 64'h0);
    @(posedge clk); #1;
    chk("hs_no_accept", 64'(ir32), 64'd1);

    // reset after slice 0 has been written
    iv32 = 1'b1; op32 = 1'b0; a32 = 32'h12345678; b32 = 32'h00000001;
    @(posedge clk); #1;
    iv32 = 1'b0;
    @(posedge clk); #1;
    chk("mid_busy", 64'(ir32), 64'd0);
    areset = 1'b1;
    #1;
    chk("abort_ir", 64'(ir32), 64'd1);
    chk("abort_ov", 64'(ov32), 64'd0);
    chk("abort_res", 64'(r32), 64'd0);
    chk("abort_cout", 64'(c32), 64'd0);
    #2 areset = 1'b0;
    @(posedge clk); #1;
    dir32("after_abort", 1'b0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);

    mask48 = '1;
    for (int i = 0; i < 1000; i++) begin
      op = 1'($urandom);
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: rb = ra;
        1: rb = 48'd1;
        2: ra = mask48;
        3: ra = 48'h800000000000;
        default: ;
      endcase
      hold = $urandom_range(0, 3);
      gap  = $urandom_range(0, 2);
      repeat (gap) @(posedge clk);
      #1;
      run48(op, ra, rb, hold, rr, rc, rv, lat);
      ref_model(48, op, 64'(ra), 64'(rb), er, ec, ev);
      chk("rnd48_res", 64'(rr), er);
      chk("rnd48_cout", 64'(rc), 64'(ec));
      chk("rnd48_lat", 64'(lat), 64'd3);
`ifdef SUB32_OVF_EN
      chk("rnd48_ovf", 64'(rv), 64'(ev));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
